// File: rtl/fir4_stream_seq.sv
// Stream sequencer for a 4-tap FIR datapath: handshake in, tap control out,
// zero-drain injection after each frame, and a 4-deep tagged output FIFO.
module fir4_stream_seq #(
  parameter int w     = 16,
  parameter int DRAIN = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [w-1:0] in_data,
  input  logic                in_last,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [w+1:0] out_data,
  output logic                out_last,
  output logic                out_fill,
  output logic signed [w-1:0] fir_a,
  output logic                fir_en,
  output logic                fir_clr,
  input  logic signed [w+1:0] fir_s,
  output logic                busy
);

  typedef enum logic [1:0] {S_CLR = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [2:0] fill_cnt_q, fill_cnt_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       p1_q, p1_d, p2_q, p2_d;
  logic [1:0] p1_tag_q, p1_tag_d, p2_tag_q, p2_tag_d;
  logic [1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0] count_q, count_d;

  logic [w+1:0] mem_data_q [4];
  logic [1:0]   mem_tag_q [4];

  logic       push, pop, shift_last, shift_fill, space;
  logic [2:0] occ;

  // Shifts in flight count against FIFO space so every write finds a free slot.
  assign occ   = count_q + {2'b00, p1_q} + {2'b00, p2_q};
  assign space = (occ < 3'd4);

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drain_cnt_d = drain_cnt_q;
    in_ready    = 1'b0;
    fir_en      = 1'b0;
    fir_clr     = 1'b0;
    fir_a       = '0;
    shift_last  = 1'b0;
    case (state_q)
      S_CLR: begin
        fir_clr    = 1'b1;
        fill_cnt_d = 3'd0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        fir_a    = in_data;
        in_ready = space & ~flush;
        fir_en   = in_valid & in_ready;
        if (fir_en && in_last) begin
          if (DRAIN == 0) begin
            state_d    = S_CLR;
            shift_last = 1'b1;
          end else begin
            state_d     = S_DRAIN;
            drain_cnt_d = 2'(DRAIN);
          end
        end
      end
      S_DRAIN: begin
        fir_en = space & ~flush;
        if (fir_en) begin
          drain_cnt_d = drain_cnt_q - 2'd1;
          if (drain_cnt_q == 2'd1) begin
            shift_last = 1'b1;
            state_d    = S_CLR;
          end
        end
      end
      default: state_d = S_CLR;
    endcase
    if (fir_en && fill_cnt_q != 3'd4) begin
      fill_cnt_d = fill_cnt_q + 3'd1;
    end
    shift_fill = (fill_cnt_d < 3'd4);
    if (flush) begin
      state_d = S_CLR;
    end
  end

  always_comb begin
    p1_d     = fir_en;
    p1_tag_d = {shift_fill, shift_last};
    p2_d     = p1_q;
    p2_tag_d = p1_tag_q;
    push     = p2_q & ~flush;
    pop      = out_valid & out_ready & ~flush;
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
    if (flush) begin
      p1_d     = 1'b0;
      p2_d     = 1'b0;
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_CLR;
      fill_cnt_q  <= 3'd0;
      drain_cnt_q <= 2'd0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      p1_tag_q    <= 2'b00;
      p2_tag_q    <= 2'b00;
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p1_tag_q    <= p1_tag_d;
      p2_tag_q    <= p2_tag_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= fir_s;
      mem_tag_q[wr_ptr_q]  <= p2_tag_q;
    end
  end

  assign out_valid = (count_q != 3'd0);
  assign out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_fill  = out_valid & mem_tag_q[rd_ptr_q][1];
  assign out_last  = out_valid & mem_tag_q[rd_ptr_q][0];
  assign busy      = (state_q == S_DRAIN) | p1_q | p2_q | out_valid;

endmodule
